// File: rtl/player_motion_sequencer_if.sv
// Signal bundle between the keyboard/collision side and the player motion
// sequencer. The master drives frame ticks, key levels and collision strobes
// and receives the speeds, state and respawn pulse. The sequencer is the slave.
interface player_motion_sequencer_if;
   logic                startOfFrame;
   logic                move_left;
   logic                move_right;
   logic                move_up;
   logic                move_down;
   logic                jump;
   logic                collision_with_ground;
   logic                collision_with_rope;
   logic                collision_with_enemy;
   logic signed [10:0]  Xspeed;
   logic signed [10:0]  Yspeed;
   logic [2:0]          state;
   logic                respawn;

   modport master (
      output startOfFrame, move_left, move_right, move_up, move_down, jump,
      output collision_with_ground, collision_with_rope, collision_with_enemy,
      input  Xspeed, Yspeed, state, respawn
   );

   modport slave (
      input  startOfFrame, move_left, move_right, move_up, move_down, jump,
      input  collision_with_ground, collision_with_rope, collision_with_enemy,
      output Xspeed, Yspeed, state, respawn
   );
endinterface

// File: rtl/player_motion_sequencer.sv
// Player motion sequencer: gathers collision strobes during a frame and, on
// each startOfFrame, picks walk/jump/fall/climb/dead and registers the signed
// X/Y speeds (1/64 pixel per frame) for the position integrator.
// Optional feature macro: PLAYER_FALL_DAMAGE_EN (a long fall kills on landing).
module player_motion_sequencer #(
   parameter int WALK_SPEED        = 40,
   parameter int JUMP_SPEED        = 90,
   parameter int CLIMB_SPEED       = 30,
   parameter int GRAVITY           = 6,
   parameter int MAX_FALL_SPEED    = 120,
   parameter int FATAL_FALL_FRAMES = 40,
   parameter int DEATH_FRAMES      = 60
) (
   input logic                      clk,
   input logic                      reset,
   player_motion_sequencer_if.slave bus
);

   localparam int DATA_W = 11;
   localparam int DCNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

`ifdef PLAYER_FALL_DAMAGE_EN
   localparam bit FALL_DAMAGE = 1'b1;
`else
   localparam bit FALL_DAMAGE = 1'b0;
`endif

   typedef logic signed [DATA_W-1:0] spd_t;

   localparam spd_t WALK_S  = spd_t'(WALK_SPEED);
   localparam spd_t JUMP_S  = spd_t'(JUMP_SPEED);
   localparam spd_t CLIMB_S = spd_t'(CLIMB_SPEED);
   localparam spd_t GRAV_S  = spd_t'(GRAVITY);
   localparam spd_t MAXF_S  = spd_t'(MAX_FALL_SPEED);
   localparam logic [DCNT_W-1:0] DEATH_LAST = DCNT_W'(DEATH_FRAMES - 1);

   typedef enum logic [2:0] {
      ST_GROUND = 3'd0,
      ST_JUMP   = 3'd1,
      ST_FALL   = 3'd2,
      ST_CLIMB  = 3'd3,
      ST_DEAD   = 3'd4
   } state_t;

   // Horizontal walking speed from the keys; left wins over right.
   function automatic spd_t walk_speed(input logic left, input logic right);
      spd_t v;
      v = '0;
      if (left)
         v = -WALK_S;
      else if (right)
         v = WALK_S;
      return v;
   endfunction

   // Rope climbing speed from the keys; up wins over down.
   function automatic spd_t climb_speed(input logic up, input logic down);
      spd_t v;
      v = '0;
      if (up)
         v = -CLIMB_S;
      else if (down)
         v = CLIMB_S;
      return v;
   endfunction

   // One frame of gravity while falling, clamped to the terminal speed.
   function automatic spd_t fall_step(input spd_t y);
      spd_t s;
      s = y + GRAV_S;
      if (s > MAXF_S)
         s = MAXF_S;
      return s;
   endfunction

   // Fall frame counter, saturating at its top value.
   function automatic logic [7:0] fall_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   state_t              state_q, state_d;
   spd_t                xspd_q, xspd_d;
   spd_t                yspd_q, yspd_d;
   logic [7:0]          fall_cnt_q, fall_cnt_d;
   logic [DCNT_W-1:0]   death_cnt_q, death_cnt_d;
   logic                gnd_f_q, gnd_f_d;
   logic                rope_f_q, rope_f_d;
   logic                enemy_f_q, enemy_f_d;
   logic                respawn_q, respawn_d;

   logic                gnd, rope, enemy;
   spd_t                y_grav;

   // State, speed, counter and sticky-flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_GROUND;
         xspd_q      <= '0;
         yspd_q      <= '0;
         fall_cnt_q  <= '0;
         death_cnt_q <= '0;
         gnd_f_q     <= 1'b0;
         rope_f_q    <= 1'b0;
         enemy_f_q   <= 1'b0;
         respawn_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         xspd_q      <= xspd_d;
         yspd_q      <= yspd_d;
         fall_cnt_q  <= fall_cnt_d;
         death_cnt_q <= death_cnt_d;
         gnd_f_q     <= gnd_f_d;
         rope_f_q    <= rope_f_d;
         enemy_f_q   <= enemy_f_d;
         respawn_q   <= respawn_d;
      end
   end

   // Flag collection and the per-frame motion decision.
   always_comb begin
      gnd   = gnd_f_q   | bus.collision_with_ground;
      rope  = rope_f_q  | bus.collision_with_rope;
      enemy = enemy_f_q | bus.collision_with_enemy;
      y_grav = yspd_q + GRAV_S;

      state_d     = state_q;
      xspd_d      = xspd_q;
      yspd_d      = yspd_q;
      fall_cnt_d  = fall_cnt_q;
      death_cnt_d = death_cnt_q;
      respawn_d   = 1'b0;
      gnd_f_d     = gnd;
      rope_f_d    = rope;
      enemy_f_d   = enemy;

      if (bus.startOfFrame) begin
         // Tick-cycle collisions are consumed by this decision only.
         gnd_f_d   = 1'b0;
         rope_f_d  = 1'b0;
         enemy_f_d = 1'b0;

         if (enemy && (state_q != ST_DEAD)) begin
            state_d     = ST_DEAD;
            xspd_d      = '0;
            yspd_d      = '0;
            death_cnt_d = '0;
         end else begin
            unique case (state_q)
               ST_GROUND: begin
                  xspd_d = walk_speed(bus.move_left, bus.move_right);
                  if (bus.jump) begin
                     state_d = ST_JUMP;
                     yspd_d  = -JUMP_S;
                  end else if (rope && (bus.move_up || bus.move_down)) begin
                     state_d = ST_CLIMB;
                     xspd_d  = '0;
                     yspd_d  = climb_speed(bus.move_up, bus.move_down);
                  end else if (!gnd) begin
                     state_d    = ST_FALL;
                     yspd_d     = '0;
                     fall_cnt_d = '0;
                  end else begin
                     yspd_d = '0;
                  end
               end
               ST_JUMP: begin
                  // Horizontal speed stays at its takeoff value.
                  if (rope) begin
                     state_d = ST_CLIMB;
                     xspd_d  = '0;
                     yspd_d  = climb_speed(bus.move_up, bus.move_down);
                  end else begin
                     yspd_d = y_grav;
                     if (!y_grav[DATA_W-1]) begin
                        state_d    = ST_FALL;
                        fall_cnt_d = '0;
                     end
                  end
               end
               ST_FALL: begin
                  yspd_d     = fall_step(yspd_q);
                  fall_cnt_d = fall_inc(fall_cnt_q);
                  if (gnd) begin
                     if (FALL_DAMAGE && (int'(fall_cnt_q) >= FATAL_FALL_FRAMES)) begin
                        state_d     = ST_DEAD;
                        xspd_d      = '0;
                        yspd_d      = '0;
                        death_cnt_d = '0;
                     end else begin
                        state_d = ST_GROUND;
                        yspd_d  = '0;
                     end
                  end else if (rope && bus.move_up) begin
                     state_d = ST_CLIMB;
                     xspd_d  = '0;
                     yspd_d  = climb_speed(bus.move_up, bus.move_down);
                  end
               end
               ST_CLIMB: begin
                  if (bus.jump) begin
                     state_d    = ST_FALL;
                     xspd_d     = walk_speed(bus.move_left, bus.move_right);
                     yspd_d     = '0;
                     fall_cnt_d = '0;
                  end else if (!rope) begin
                     state_d    = ST_FALL;
                     xspd_d     = '0;
                     yspd_d     = '0;
                     fall_cnt_d = '0;
                  end else if (gnd && bus.move_down) begin
                     state_d = ST_GROUND;
                     xspd_d  = '0;
                     yspd_d  = '0;
                  end else begin
                     xspd_d = '0;
                     yspd_d = climb_speed(bus.move_up, bus.move_down);
                  end
               end
               ST_DEAD: begin
                  xspd_d = '0;
                  yspd_d = '0;
                  if (death_cnt_q == DEATH_LAST) begin
                     state_d   = ST_GROUND;
                     respawn_d = 1'b1;
                  end else begin
                     death_cnt_d = death_cnt_q + DCNT_W'(1);
                  end
               end
               default: begin
                  state_d = ST_GROUND;
                  xspd_d  = '0;
                  yspd_d  = '0;
               end
            endcase
         end
      end
   end

   assign bus.Xspeed  = xspd_q;
   assign bus.Yspeed  = yspd_q;
   assign bus.state   = state_q;
   assign bus.respawn = respawn_q;

endmodule
